window_fetch_ctrl: RTL and testbench

//  Sequencer that feeds the HOR_SIZE x VER_SIZE column-major pixel shift window from a frame-buffer BRAM.
//  Per window row: issues reads column by column (VER_SIZE pixels/column), streams them gap-free into the shifter,

---
 rtl/win_fetch_pkg.sv | 14 +
 rtl/valid_delay_line.sv | 18 +
 rtl/window_fetch_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_window_fetch_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/win_fetch_pkg.sv
// rtl/win_fetch_pkg.sv - shared state encoding, defaults and coordinate type for the window fetch sequencer
package win_fetch_pkg;
  localparam int DIM_W_DEF  = 11;
  localparam int RD_LAT_DEF = 2;

  typedef logic [DIM_W_DEF-1:0] coord_t;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_WAIT  = 3'd1;
  localparam state_t ST_FETCH = 3'd2;
  localparam state_t ST_DRAIN = 3'd3;
  localparam state_t ST_DONE  = 3'd4;
endpackage

// File: rtl/valid_delay_line.sv
// rtl/valid_delay_line.sv - shift-register pipe aligning read enables with returned pixel data
module valid_delay_line #(
  parameter int DEPTH = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic [DEPTH-1:0] o_taps
);
  logic [DEPTH-1:0] r_pipe;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_pipe <= '0;
    else          r_pipe <= {r_pipe[DEPTH-2:0], i_valid};
  end

  assign o_taps = r_pipe;
endmodule

// File: rtl/window_fetch_ctrl.sv
// rtl/window_fetch_ctrl.sv - row-by-row column-major BRAM fetch sequencer for the pixel shift window
// Optional stall counter built when WIN_FETCH_PERF_EN is defined.
module window_fetch_ctrl
  import win_fetch_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int HOR_SIZE   = 4,
  parameter int VER_SIZE   = 4,
  parameter int ADDR_W     = 17,
  parameter int DIM_W      = DIM_W_DEF,
  parameter int RD_LAT     = RD_LAT_DEF,
  parameter int ROW_STRIDE = 1
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              start_in,
  input  logic [DIM_W-1:0]  cfg_width_in,
  input  logic [DIM_W-1:0]  cfg_height_in,
  input  logic              consumer_ready_in,
  output logic              rd_en_out,
  output logic [ADDR_W-1:0] rd_addr_out,
  input  logic [WIDTH-1:0]  rd_data_in,
  output logic              shift_valid_out,
  output logic [WIDTH-1:0]  pixel_out,
  output logic [DIM_W-1:0]  win_x_out,
  output logic [DIM_W-1:0]  win_y_out,
  output logic              busy_out,
  output logic              frame_done_out,
  output logic              cfg_err_out,
  output logic [31:0]       stall_cycles_out
);
  localparam int JW  = (VER_SIZE > 1) ? $clog2(VER_SIZE) : 1;
  localparam int DW1 = DIM_W + 1;
  localparam logic [JW-1:0] J_LAST = JW'(VER_SIZE - 1);

  state_t             r_state;
  logic [DIM_W-1:0]   r_w, r_h, r_y0, r_x;
  logic [JW-1:0]      r_j;
  logic [ADDR_W-1:0]  r_addr, r_col_base, r_row_base, r_stride_w;
  logic [DIM_W-1:0]   r_ox, r_oy, r_win_x, r_win_y;
  logic [JW-1:0]      r_oj;
  logic [WIDTH-1:0]   r_pix;
  logic               r_cfg_err;

  logic [RD_LAT:0]    w_taps;
  logic [ADDR_W-1:0]  w_stride_w, w_next_row;
  logic [DW1-1:0]     w_next_y;
  logic               w_cfg_ok, w_accept, w_more_rows, w_col_last, w_x_last, w_vld;

  valid_delay_line #(.DEPTH(RD_LAT + 1)) u_vdl (
    .i_clk   (clk_in),
    .i_rst_n (rst_n_in),
    .i_valid (rd_en_out),
    .o_taps  (w_taps)
  );

  // Row stride in addresses, accumulated from the width so no multiplier is needed.
  always_comb begin
    w_stride_w = '0;
    for (int k = 0; k < ROW_STRIDE; k++) w_stride_w = w_stride_w + ADDR_W'(cfg_width_in);
  end

  assign w_cfg_ok    = (cfg_width_in >= DIM_W'(HOR_SIZE)) && (cfg_height_in >= DIM_W'(VER_SIZE));
  assign w_accept    = (r_state == ST_IDLE) && start_in && w_cfg_ok;
  assign w_next_y    = {1'b0, r_y0} + DW1'(ROW_STRIDE);
  assign w_more_rows = (w_next_y + DW1'(VER_SIZE)) <= {1'b0, r_h};
  assign w_col_last  = (r_j == J_LAST);
  assign w_x_last    = (r_x == r_w - DIM_W'(1));
  assign w_next_row  = r_row_base + r_stride_w;
  assign w_vld       = w_taps[RD_LAT];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state    <= ST_IDLE;
      r_w        <= '0;
      r_h        <= '0;
      r_y0       <= '0;
      r_x        <= '0;
      r_j        <= '0;
      r_addr     <= '0;
      r_col_base <= '0;
      r_row_base <= '0;
      r_stride_w <= '0;
      r_cfg_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (start_in) begin
          if (!w_cfg_ok) begin
            r_cfg_err <= 1'b1;
          end else begin
            r_cfg_err  <= 1'b0;
            r_w        <= cfg_width_in;
            r_h        <= cfg_height_in;
            r_stride_w <= w_stride_w;
            r_y0       <= '0;
            r_x        <= '0;
            r_j        <= '0;
            r_addr     <= '0;
            r_col_base <= '0;
            r_row_base <= '0;
            r_state    <= ST_WAIT;
          end
        end
        ST_WAIT: if (consumer_ready_in) r_state <= ST_FETCH;
        ST_FETCH: begin
          if (!w_col_last) begin
            r_j    <= r_j + JW'(1);
            r_addr <= r_addr + ADDR_W'(r_w);
          end else begin
            r_j <= '0;
            if (w_x_last) begin
              r_state <= ST_DRAIN;
            end else begin
              r_x        <= r_x + DIM_W'(1);
              r_col_base <= r_col_base + ADDR_W'(1);
              r_addr     <= r_col_base + ADDR_W'(1);
            end
          end
        end
        ST_DRAIN: if (w_taps == '0) begin
          if (w_more_rows) begin
            r_state    <= ST_WAIT;
            r_y0       <= w_next_y[DIM_W-1:0];
            r_x        <= '0;
            r_row_base <= w_next_row;
            r_col_base <= w_next_row;
            r_addr     <= w_next_row;
          end else begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Output-side column tracking mirrors what the shifter has absorbed, so coordinates land with its valid_out.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_ox    <= '0;
      r_oy    <= '0;
      r_oj    <= '0;
      r_win_x <= '0;
      r_win_y <= '0;
    end else if (w_accept) begin
      r_ox <= '0;
      r_oy <= '0;
      r_oj <= '0;
    end else if (w_vld) begin
      if (r_oj != J_LAST) begin
        r_oj <= r_oj + JW'(1);
      end else begin
        r_oj <= '0;
        if (r_ox >= DIM_W'(HOR_SIZE - 1)) begin
          r_win_x <= r_ox - DIM_W'(HOR_SIZE - 1);
          r_win_y <= r_oy;
        end
        if (r_ox == r_w - DIM_W'(1)) begin
          r_ox <= '0;
          r_oy <= r_oy + DIM_W'(ROW_STRIDE);
        end else begin
          r_ox <= r_ox + DIM_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)               r_pix <= '0;
    else if (w_taps[RD_LAT - 1]) r_pix <= rd_data_in;
  end

`ifdef WIN_FETCH_PERF_EN
  logic [31:0] r_stall;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)
      r_stall <= '0;
    else if (w_accept)
      r_stall <= '0;
    else if ((r_state == ST_WAIT) && !consumer_ready_in && (r_stall != 32'hFFFF_FFFF))
      r_stall <= r_stall + 32'd1;
  end

  assign stall_cycles_out = r_stall;
`else
  assign stall_cycles_out = 32'd0;
`endif

  assign rd_en_out       = (r_state == ST_FETCH);
  assign rd_addr_out     = r_addr;
  assign shift_valid_out = w_vld;
  assign pixel_out       = r_pix;
  assign win_x_out       = r_win_x;
  assign win_y_out       = r_win_y;
  assign busy_out        = (r_state != ST_IDLE);
  assign frame_done_out  = (r_state == ST_DONE);
  assign cfg_err_out     = r_cfg_err;
endmodule

// File: tb/tb_window_fetch_ctrl.sv
// tb/tb_window_fetch_ctrl.sv - directed self-checking bench for window_fetch_ctrl (honours WIN_FETCH_PERF_EN)
module tb_window_fetch_ctrl;
  localparam int WIDTH = 16, HOR = 4, VER = 4, ADDR_W = 17, DIM_W = 11, RD_LAT = 2, STRIDE = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [DIM_W-1:0]  cfg_w = '0, cfg_h = '0;
  logic              ready = 1'b1;
  logic              rd_en_out;
  logic [ADDR_W-1:0] rd_addr_out;
  logic [WIDTH-1:0]  rd_data_in;
  logic              shift_valid_out;
  logic [WIDTH-1:0]  pixel_out;
  logic [DIM_W-1:0]  win_x_out, win_y_out;
  logic              busy_out, frame_done_out, cfg_err_out;
  logic [31:0]       stall_cycles_out;

  always #5 clk = ~clk;

  window_fetch_ctrl #(
    .WIDTH(WIDTH), .HOR_SIZE(HOR), .VER_SIZE(VER), .ADDR_W(ADDR_W),
    .DIM_W(DIM_W), .RD_LAT(RD_LAT), .ROW_STRIDE(STRIDE)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start),
    .cfg_width_in(cfg_w), .cfg_height_in(cfg_h), .consumer_ready_in(ready),
    .rd_en_out(rd_en_out), .rd_addr_out(rd_addr_out), .rd_data_in(rd_data_in),
    .shift_valid_out(shift_valid_out), .pixel_out(pixel_out),
    .win_x_out(win_x_out), .win_y_out(win_y_out), .busy_out(busy_out),
    .frame_done_out(frame_done_out), .cfg_err_out(cfg_err_out),
    .stall_cycles_out(stall_cycles_out)
  );

  // BRAM model: data = address, RD_LAT cycles after the enable.
  logic [WIDTH-1:0] bq [RD_LAT];
  always @(posedge clk) begin
    bq[0] <= rd_en_out ? rd_addr_out[WIDTH-1:0] : 16'hDEAD;
    for (int i = 1; i < RD_LAT; i++) bq[i] <= bq[i-1];
  end
  assign rd_data_in = bq[RD_LAT-1];

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Monitor plus a counting shifter model: valid_out follows each full VER-pixel column once HOR columns are in.
  int rd_q[$], pix_q[$], rl_q[$];
  logic [31:0] win_q[$];
  int scnt = 0, done_cnt = 0, spur = 0;
  bit pend = 1'b0;
  logic [DIM_W-1:0] px = '0, py = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      scnt = 0; pend = 1'b0; px = win_x_out; py = win_y_out;
    end else begin
      if (pend) win_q.push_back({5'd0, win_y_out, 5'd0, win_x_out});
      else if (win_x_out != px || win_y_out != py) spur++;
      px = win_x_out; py = win_y_out; pend = 1'b0;
      if (shift_valid_out) begin
        scnt++;
        pix_q.push_back(int'(pixel_out));
        if (scnt >= HOR*VER && scnt % VER == 0) pend = 1'b1;
      end else if (scnt != 0) begin
        rl_q.push_back(scnt);
        scnt = 0;
      end
      if (rd_en_out) rd_q.push_back(int'(rd_addr_out));
      if (frame_done_out) done_cnt++;
    end
  end

  function automatic int q_at(input int idx);
    return (idx < rd_q.size()) ? rd_q[idx] : -1;
  endfunction

  task automatic run_frame(input int w, input int h);
    int nrows, idx, tw;
    @(negedge clk);
    rd_q.delete(); pix_q.delete(); rl_q.delete(); win_q.delete();
    done_cnt = 0; spur = 0;
    cfg_w = DIM_W'(w); cfg_h = DIM_W'(h); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_after_start", busy_out, 1);
    chk("err_after_start", cfg_err_out, 0);
    tw = 0;
    while (done_cnt == 0 && tw < 3000) begin @(negedge clk); tw++; end
    chk("frame_done_seen", done_cnt != 0, 1);
    repeat (6) @(negedge clk);
    chk("frame_done_once", done_cnt, 1);
    chk("busy_end", busy_out, 0);
    nrows = (h - VER) / STRIDE + 1;
    chk("n_reads", rd_q.size(), nrows * w * VER);
    chk("n_pixels", pix_q.size(), nrows * w * VER);
    chk("n_rows", rl_q.size(), nrows);
    idx = 0;
    for (int r = 0; r < nrows; r++)
      for (int x = 0; x < w; x++)
        for (int j = 0; j < VER; j++) begin
          if (idx < rd_q.size())  chk("rd_addr", rd_q[idx], (r*STRIDE + j) * w + x);
          if (idx < pix_q.size()) chk("pixel", pix_q[idx], (r*STRIDE + j) * w + x);
          idx++;
        end
    for (int r = 0; r < rl_q.size(); r++) chk("row_len", rl_q[r], w * VER);
    chk("n_windows", win_q.size(), nrows * (w - HOR + 1));
    idx = 0;
    for (int r = 0; r < nrows; r++)
      for (int k = 0; k <= w - HOR; k++) begin
        if (idx < win_q.size()) chk("win_xy", win_q[idx], ((r*STRIDE) << 16) | k);
        idx++;
      end
    chk("win_spurious", spur, 0);
  endtask

  task automatic inject_start();
    int t = 0;
    do begin @(negedge clk); t++; end while (!rd_en_out && t < 500);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic stall_ctrl();
    int t, rd_seen;
    t = 0;
    do begin @(negedge clk); t++; end while (!rd_en_out && t < 500);
    ready = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (rd_en_out && t < 500);
    rd_seen = 0;
    repeat (14) begin @(negedge clk); if (rd_en_out) rd_seen++; end
    ready = 1'b1;
    chk("stall_no_reads", rd_seen, 0);
    @(negedge clk);
    chk("stall_resume", rd_en_out, 1);
`ifdef WIN_FETCH_PERF_EN
    chk("stall_cycles", stall_cycles_out, 10);
`else
    chk("stall_cycles", stall_cycles_out, 0);
`endif
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"}, rd_en_out, 0);
    chk({tag, "_rd_addr"}, rd_addr_out, 0);
    chk({tag, "_shift_valid"}, shift_valid_out, 0);
    chk({tag, "_pixel"}, pixel_out, 0);
    chk({tag, "_win_x"}, win_x_out, 0);
    chk({tag, "_win_y"}, win_y_out, 0);
    chk({tag, "_busy"}, busy_out, 0);
    chk({tag, "_frame_done"}, frame_done_out, 0);
    chk({tag, "_cfg_err"}, cfg_err_out, 0);
    chk({tag, "_stall"}, stall_cycles_out, 0);
  endtask

  initial begin
    int t, rd_seen;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // W=6,H=5 with a stray start during FETCH
    fork
      run_frame(6, 5);
      inject_start();
    join
    chk("a_addr0", q_at(0), 0);
    chk("a_addr1", q_at(1), 6);
    chk("a_addr2", q_at(2), 12);
    chk("a_addr3", q_at(3), 18);
    chk("a_addr4", q_at(4), 1);
    chk("a_addr5", q_at(5), 7);
    chk("a_row2_0", q_at(24), 6);
    chk("a_row2_1", q_at(25), 12);
    chk("a_row2_2", q_at(26), 18);
    chk("a_row2_3", q_at(27), 24);
    chk("a_last", q_at(47), 29);
    chk("a_stall", stall_cycles_out, 0);

    // Same frame, consumer not ready for 10 WAIT cycles before row 2
    fork
      run_frame(6, 5);
      stall_ctrl();
    join

    // Bad configs then an exact fit
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      cfg_w = (b == 0) ? DIM_W'(3) : DIM_W'(6);
      cfg_h = (b == 0) ? DIM_W'(5) : DIM_W'(3);
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      rd_seen = 0;
      repeat (5) begin
        if (rd_en_out) rd_seen++;
        @(negedge clk);
      end
      chk("bad_cfg_err", cfg_err_out, 1);
      chk("bad_cfg_busy", busy_out, 0);
      chk("bad_cfg_reads", rd_seen, 0);
    end
    run_frame(4, 4);
    chk("fit_win_x", win_x_out, 0);
    chk("fit_win_y", win_y_out, 0);

    // Reset mid-FETCH, then a clean restart
    @(negedge clk);
    cfg_w = DIM_W'(6); cfg_h = DIM_W'(5); start = 1'b1;
    @(negedge clk); start = 1'b0;
    t = 0;
    while (!rd_en_out && t < 500) begin @(negedge clk); t++; end
    repeat (8) @(negedge clk);
    chk("midrst_pre_busy", busy_out, 1);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(6, 5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
